// File: rtl/ssd_pkg.sv
// ssd_pkg: seven-segment constants shared between the scan decoder and the
// display driver. Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
// Contents: digit/sign/op glyphs, digit slot indices, op codes, scan FSM
// state type and small decode helpers (anode index, sign, op).
package ssd_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;

    localparam logic [6:0] GLYPH_NEG   = 7'b0100101;
    localparam logic [6:0] GLYPH_POS   = 7'b0101110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_OP_00 = 7'b0100000;
    localparam logic [6:0] GLYPH_OP_01 = 7'b0100100;
    localparam logic [6:0] GLYPH_OP_10 = 7'b0011001;
    localparam logic [6:0] GLYPH_OP_11 = 7'b1111000;

    localparam logic [1:0] OP_CODE_00  = 2'b00;
    localparam logic [1:0] OP_CODE_01  = 2'b01;
    localparam logic [1:0] OP_CODE_10  = 2'b10;
    localparam logic [1:0] OP_CODE_11  = 2'b11;

    localparam logic [2:0] DIG_X_MAG    = 3'd0;
    localparam logic [2:0] DIG_X_SIGN   = 3'd1;
    localparam logic [2:0] DIG_Y_MAG    = 3'd2;
    localparam logic [2:0] DIG_Y_SIGN   = 3'd3;
    localparam logic [2:0] DIG_RES_ONES = 3'd4;
    localparam logic [2:0] DIG_RES_TENS = 3'd5;
    localparam logic [2:0] DIG_RES_SIGN = 3'd6;
    localparam logic [2:0] DIG_OP       = 3'd7;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HOLD   = 1'b1
    } scan_state_e;

    typedef enum logic [1:0] {
        SIGN_POS   = 2'd0,
        SIGN_NEG   = 2'd1,
        SIGN_BLANK = 2'd2,
        SIGN_BAD   = 2'd3
    } sign_e;

    // Returns {one_hot, index} for an active-low anode bus.
    function automatic logic [3:0] an_decode(input logic [7:0] an_n);
        case (an_n)
            8'b11111110: an_decode = {1'b1, 3'd0};
            8'b11111101: an_decode = {1'b1, 3'd1};
            8'b11111011: an_decode = {1'b1, 3'd2};
            8'b11110111: an_decode = {1'b1, 3'd3};
            8'b11101111: an_decode = {1'b1, 3'd4};
            8'b11011111: an_decode = {1'b1, 3'd5};
            8'b10111111: an_decode = {1'b1, 3'd6};
            8'b01111111: an_decode = {1'b1, 3'd7};
            default:     an_decode = {1'b0, 3'd0};
        endcase
    endfunction

    function automatic sign_e sign_decode(input logic [6:0] glyph);
        case (glyph)
            GLYPH_POS:   sign_decode = SIGN_POS;
            GLYPH_NEG:   sign_decode = SIGN_NEG;
            GLYPH_BLANK: sign_decode = SIGN_BLANK;
            default:     sign_decode = SIGN_BAD;
        endcase
    endfunction

    // Returns {valid, op_code}.
    function automatic logic [2:0] op_decode(input logic [6:0] glyph);
        case (glyph)
            GLYPH_OP_00: op_decode = {1'b1, OP_CODE_00};
            GLYPH_OP_01: op_decode = {1'b1, OP_CODE_01};
            GLYPH_OP_10: op_decode = {1'b1, OP_CODE_10};
            GLYPH_OP_11: op_decode = {1'b1, OP_CODE_11};
            default:     op_decode = {1'b0, OP_CODE_00};
        endcase
    endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// ssd_glyph_decode: combinational decimal-digit glyph decoder.
// Ports: glyph (7-bit active-low segments) -> value (0..9), valid (1 when
// glyph is one of the ten digit shapes; value is 0 otherwise).
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [6:0] glyph,
    output logic [3:0] value,
    output logic       valid
);

    // Glyph lookup; anything outside the digit set is flagged invalid.
    always_comb begin
        value = 4'd0;
        valid = 1'b1;
        case (glyph)
            GLYPH_0: value = 4'd0;
            GLYPH_1: value = 4'd1;
            GLYPH_2: value = 4'd2;
            GLYPH_3: value = 4'd3;
            GLYPH_4: value = 4'd4;
            GLYPH_5: value = 4'd5;
            GLYPH_6: value = 4'd6;
            GLYPH_7: value = 4'd7;
            GLYPH_8: value = 4'd8;
            GLYPH_9: value = 4'd9;
            default: begin
                value = 4'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: observes a multiplexed 8-digit seven-segment display
// (AN/sseg, active-low) and reconstructs the operands, result and op shown.
// Ports: clk, rst (sync, active-high); sseg[6:0], AN[7:0] observed buses;
// x_mag/y_mag/x_neg/y_neg, result/res_neg/res_blank, op: decoded frame;
// frame_valid: one-cycle pulse on update; seg_err: illegal glyph in frame;
// an_err: one-cycle pulse when a settled AN is not one-hot; stale: no capture
// for STALE_CYC cycles.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int SETTLE    = 4,
    parameter int STALE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sseg,
    input  logic [7:0] AN,
    output logic [3:0] x_mag,
    output logic [3:0] y_mag,
    output logic       x_neg,
    output logic       y_neg,
    output logic [7:0] result,
    output logic       res_neg,
    output logic       res_blank,
    output logic [1:0] op,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       an_err,
    output logic       stale
);

    localparam logic [7:0]  SETTLE_MAX = SETTLE[7:0];
    localparam logic [23:0] STALE_MAX  = STALE_CYC[23:0];

    logic [7:0]      an_s1_r, an_s2_r, an_prev_r;
    logic [6:0]      sseg_s1_r, sseg_s2_r, sseg_prev_r;
    scan_state_e     state_r, state_nxt_s;
    logic [7:0]      settle_cnt_r, settle_cnt_nxt_s;
    logic [7:0][6:0] slot_r, slot_nxt_s;
    logic [7:0]      mask_r, mask_nxt_s;
    logic [23:0]     stale_cnt_r, stale_cnt_nxt_s;
    logic            changed_s, capture_s, an_bad_s, frame_done_s;
    logic [3:0]      an_dec_s;

    logic [3:0] x_val_s, y_val_s, ones_val_s, tens_val_s;
    logic       x_ok_s, y_ok_s, ones_ok_s, tens_ok_s;
    sign_e      x_sign_s, y_sign_s, r_sign_s;
    logic [2:0] op_dec_s;
    logic [7:0] result_calc_s;
    logic       frame_ok_s;

    logic [3:0] x_mag_r, y_mag_r;
    logic       x_neg_r, y_neg_r, res_neg_r, res_blank_r;
    logic [7:0] result_r;
    logic [1:0] op_r;
    logic       frame_valid_r, seg_err_r, an_err_r, stale_r;

    assign changed_s = (an_s2_r != an_prev_r) || (sseg_s2_r != sseg_prev_r);
    assign an_dec_s  = an_decode(an_s2_r);

    // Input synchroniser plus the one-cycle-old copy used for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_s1_r     <= 8'hFF;
            an_s2_r     <= 8'hFF;
            an_prev_r   <= 8'hFF;
            sseg_s1_r   <= GLYPH_BLANK;
            sseg_s2_r   <= GLYPH_BLANK;
            sseg_prev_r <= GLYPH_BLANK;
        end else begin
            an_s1_r     <= AN;
            an_s2_r     <= an_s1_r;
            an_prev_r   <= an_s2_r;
            sseg_s1_r   <= sseg;
            sseg_s2_r   <= sseg_s1_r;
            sseg_prev_r <= sseg_s2_r;
        end
    end

    // Settle/hold FSM: one capture decision per stable dwell.
    always_comb begin
        state_nxt_s      = state_r;
        settle_cnt_nxt_s = settle_cnt_r;
        capture_s        = 1'b0;
        an_bad_s         = 1'b0;
        case (state_r)
            ST_SETTLE: begin
                if (changed_s) begin
                    settle_cnt_nxt_s = 8'd0;
                end else if ((settle_cnt_r + 8'd1) >= SETTLE_MAX) begin
                    settle_cnt_nxt_s = 8'd0;
                    state_nxt_s      = ST_HOLD;
                    if (an_dec_s[3]) begin
                        capture_s = 1'b1;
                    end else begin
                        an_bad_s = 1'b1;
                    end
                end else begin
                    settle_cnt_nxt_s = settle_cnt_r + 8'd1;
                end
            end
            ST_HOLD: begin
                if (changed_s) begin
                    state_nxt_s      = ST_SETTLE;
                    settle_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s      = ST_SETTLE;
                settle_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Slot/mask update; the frame decodes from slot_nxt_s so the final
    // capture is visible to the decoders in the same cycle.
    always_comb begin
        slot_nxt_s = slot_r;
        mask_nxt_s = mask_r;
        if (capture_s) begin
            slot_nxt_s[an_dec_s[2:0]] = sseg_s2_r;
            mask_nxt_s[an_dec_s[2:0]] = 1'b1;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    assign frame_done_s = capture_s && (mask_nxt_s == 8'hFF);

    // Stale counter: cleared by any capture, saturates at STALE_MAX.
    always_comb begin
        stale_cnt_nxt_s = stale_cnt_r;
        if (capture_s) begin
            stale_cnt_nxt_s = 24'd0;
        end else if (stale_cnt_r != STALE_MAX) begin
            stale_cnt_nxt_s = stale_cnt_r + 24'd1;
        end else begin
            stale_cnt_nxt_s = stale_cnt_r;
        end
    end

    ssd_glyph_decode u_dec_x    (.glyph(slot_nxt_s[DIG_X_MAG]),    .value(x_val_s),    .valid(x_ok_s));
    ssd_glyph_decode u_dec_y    (.glyph(slot_nxt_s[DIG_Y_MAG]),    .value(y_val_s),    .valid(y_ok_s));
    ssd_glyph_decode u_dec_ones (.glyph(slot_nxt_s[DIG_RES_ONES]), .value(ones_val_s), .valid(ones_ok_s));
    ssd_glyph_decode u_dec_tens (.glyph(slot_nxt_s[DIG_RES_TENS]), .value(tens_val_s), .valid(tens_ok_s));

    assign x_sign_s      = sign_decode(slot_nxt_s[DIG_X_SIGN]);
    assign y_sign_s      = sign_decode(slot_nxt_s[DIG_Y_SIGN]);
    assign r_sign_s      = sign_decode(slot_nxt_s[DIG_RES_SIGN]);
    assign op_dec_s      = op_decode(slot_nxt_s[DIG_OP]);
    assign result_calc_s = ({4'd0, tens_val_s} * 8'd10) + {4'd0, ones_val_s};

    // BLANK is only a legal sign on the result digit.
    assign frame_ok_s = x_ok_s && y_ok_s && ones_ok_s && tens_ok_s && op_dec_s[2]
                     && (x_sign_s == SIGN_POS || x_sign_s == SIGN_NEG)
                     && (y_sign_s == SIGN_POS || y_sign_s == SIGN_NEG)
                     && (r_sign_s != SIGN_BAD);

    // Control state, slots, mask and stale counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= 8'd0;
            slot_r       <= {8{GLYPH_BLANK}};
            mask_r       <= 8'h00;
            stale_cnt_r  <= 24'd0;
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_cnt_nxt_s;
            slot_r       <= slot_nxt_s;
            mask_r       <= frame_done_s ? 8'h00 : mask_nxt_s;
            stale_cnt_r  <= stale_cnt_nxt_s;
        end
    end

    // Registered outputs; an illegal field keeps its previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_mag_r       <= 4'd0;
            y_mag_r       <= 4'd0;
            x_neg_r       <= 1'b0;
            y_neg_r       <= 1'b0;
            result_r      <= 8'd0;
            res_neg_r     <= 1'b0;
            res_blank_r   <= 1'b1;
            op_r          <= OP_CODE_00;
            frame_valid_r <= 1'b0;
            seg_err_r     <= 1'b0;
            an_err_r      <= 1'b0;
            stale_r       <= 1'b0;
        end else begin
            frame_valid_r <= frame_done_s;
            an_err_r      <= an_bad_s;
            stale_r       <= (stale_cnt_nxt_s == STALE_MAX);
            if (frame_done_s) begin
                seg_err_r <= !frame_ok_s;
                if (x_ok_s) x_mag_r <= x_val_s;
                if (y_ok_s) y_mag_r <= y_val_s;
                if (x_sign_s == SIGN_POS || x_sign_s == SIGN_NEG) x_neg_r <= (x_sign_s == SIGN_NEG);
                if (y_sign_s == SIGN_POS || y_sign_s == SIGN_NEG) y_neg_r <= (y_sign_s == SIGN_NEG);
                if (ones_ok_s && tens_ok_s) result_r <= result_calc_s;
                if (r_sign_s != SIGN_BAD) begin
                    res_neg_r   <= (r_sign_s == SIGN_NEG);
                    res_blank_r <= (r_sign_s == SIGN_BLANK);
                end
                if (op_dec_s[2]) op_r <= op_dec_s[1:0];
            end
        end
    end

    assign x_mag       = x_mag_r;
    assign y_mag       = y_mag_r;
    assign x_neg       = x_neg_r;
    assign y_neg       = y_neg_r;
    assign result      = result_r;
    assign res_neg     = res_neg_r;
    assign res_blank   = res_blank_r;
    assign op          = op_r;
    assign frame_valid = frame_valid_r;
    assign seg_err     = seg_err_r;
    assign an_err      = an_err_r;
    assign stale       = stale_r;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
module tb_ssd_scan_decoder;

    localparam int STALE = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] sseg = 7'b1111111;
    logic [7:0] AN = 8'hFF;
    logic [3:0] x_mag, y_mag;
    logic       x_neg, y_neg, res_neg, res_blank;
    logic [7:0] result;
    logic [1:0] op;
    logic       frame_valid, seg_err, an_err, stale;

    ssd_scan_decoder #(.SETTLE(4), .STALE_CYC(STALE)) dut (
        .clk(clk), .rst(rst), .sseg(sseg), .AN(AN),
        .x_mag(x_mag), .y_mag(y_mag), .x_neg(x_neg), .y_neg(y_neg),
        .result(result), .res_neg(res_neg), .res_blank(res_blank), .op(op),
        .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] x_mag;
        logic       x_neg;
        logic [3:0] y_mag;
        logic       y_neg;
        logic [7:0] result;
        logic       res_neg;
        logic       res_blank;
        logic [1:0] op;
        logic       seg_err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   frames_seen = 0;
    int   an_err_seen = 0;
    int   exp_an_err = 0;
    logic fv_prev = 1'b0;
    logic ae_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dg(input int d);
        case (d)
            0: dg = 7'b1000000; 1: dg = 7'b1111001; 2: dg = 7'b0100100;
            3: dg = 7'b0110000; 4: dg = 7'b0011001; 5: dg = 7'b0010010;
            6: dg = 7'b0000010; 7: dg = 7'b1111000; 8: dg = 7'b0000000;
            9: dg = 7'b0010000; default: dg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] sg(input int s);
        case (s)
            0: sg = 7'b0101110;  // POS
            1: sg = 7'b0100101;  // NEG
            default: sg = 7'b1111111;  // BLANK
        endcase
    endfunction

    function automatic logic [6:0] og(input int o);
        case (o)
            0: og = 7'b0100000; 1: og = 7'b0100100;
            2: og = 7'b0011001; default: og = 7'b1111000;
        endcase
    endfunction

    function automatic logic [7:0][6:0] mk_frame(input int x, input int xs, input int y,
                                                 input int ys, input int tens, input int ones,
                                                 input int rs, input int o);
        logic [7:0][6:0] f;
        f[0] = dg(x);    f[1] = sg(xs);   f[2] = dg(y);    f[3] = sg(ys);
        f[4] = dg(ones); f[5] = dg(tens); f[6] = sg(rs);   f[7] = og(o);
        return f;
    endfunction

    task automatic drive_digit(input int idx, input logic [6:0] g, input int dwell);
        logic [7:0] one;
        one = 8'd1 << idx;
        @(negedge clk);
        AN   = ~one;
        sseg = g;
        repeat (dwell - 1) @(negedge clk);
    endtask

    task automatic scan_range(input logic [7:0][6:0] f, input int lo, input int hi, input int dwell);
        for (int i = lo; i <= hi; i++) drive_digit(i, f[i], dwell);
    endtask

    task automatic push(input int x, input int xn, input int y, input int yn, input int res,
                        input int rn, input int rb, input int o, input int se);
        exp_t e;
        e.x_mag = 4'(x); e.x_neg = 1'(xn); e.y_mag = 4'(y); e.y_neg = 1'(yn);
        e.result = 8'(res); e.res_neg = 1'(rn); e.res_blank = 1'(rb);
        e.op = 2'(o); e.seg_err = 1'(se);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; AN = 8'hFF; sseg = 7'b1111111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_x_mag", x_mag, 0);       chk("rst_y_mag", y_mag, 0);
        chk("rst_x_neg", x_neg, 0);       chk("rst_y_neg", y_neg, 0);
        chk("rst_result", result, 0);     chk("rst_res_neg", res_neg, 0);
        chk("rst_res_blank", res_blank, 1); chk("rst_op", op, 0);
        chk("rst_frame_valid", frame_valid, 0); chk("rst_seg_err", seg_err, 0);
        chk("rst_an_err", an_err, 0);     chk("rst_stale", stale, 0);
        // Idle bus (AN=FF) settles into a single non-one-hot error pulse.
        repeat (12) @(negedge clk);
        exp_an_err++;
    endtask

    // Monitor: pops expected frames whenever the DUT presents one.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (frame_valid && fv_prev) chk("frame_valid_width", 2, 1);
            if (an_err && ae_prev) chk("an_err_width", 2, 1);
            if (an_err) an_err_seen++;
            if (frame_valid) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("x_mag", x_mag, e.x_mag);       chk("x_neg", x_neg, e.x_neg);
                    chk("y_mag", y_mag, e.y_mag);       chk("y_neg", y_neg, e.y_neg);
                    chk("result", result, e.result);    chk("res_neg", res_neg, e.res_neg);
                    chk("res_blank", res_blank, e.res_blank);
                    chk("op", op, e.op);                chk("seg_err", seg_err, e.seg_err);
                end
            end
        end
        fv_prev = frame_valid;
        ae_prev = an_err;
    end

    initial begin
        logic [7:0][6:0] f;
        do_reset();
        chk("an_err_after_reset", an_err_seen, exp_an_err);

        // x=3, y=-5, op 01, result +15.
        push(3, 0, 5, 1, 15, 0, 0, 1, 0);
        f = mk_frame(3, 0, 5, 1, 1, 5, 0, 1);
        scan_range(f, 0, 7, 20);

        // Blank result sign with result 0.
        push(9, 1, 0, 0, 0, 0, 1, 3, 0);
        f = mk_frame(9, 1, 0, 0, 0, 0, 2, 3);
        scan_range(f, 0, 7, 20);

        // Upper bound result -99.
        push(8, 0, 6, 1, 99, 1, 0, 2, 0);
        f = mk_frame(8, 0, 6, 1, 9, 9, 1, 2);
        scan_range(f, 0, 7, 20);

        // Illegal ones glyph, plus a non-one-hot AN mid-frame.
        push(1, 1, 2, 0, 99, 0, 0, 0, 1);
        f = mk_frame(1, 1, 2, 0, 4, 0, 0, 0);
        f[4] = 7'b1010101;
        scan_range(f, 0, 3, 20);
        @(negedge clk);
        AN = 8'b11110011;
        repeat (9) @(negedge clk);
        exp_an_err++;
        scan_range(f, 4, 7, 20);
        chk("an_err_count_bad_an", an_err_seen, exp_an_err);
        chk("frames_after_bad_an", frames_seen, 4);

        // Dwell too short to settle: no captures, stale eventually rises.
        chk("stale_low_start", stale, 0);
        f = mk_frame(2, 0, 2, 0, 2, 2, 0, 0);
        for (int p = 0; p < 8; p++) scan_range(f, 0, 7, 3);
        chk("stale_low_mid", stale, 0);
        for (int p = 0; p < 8; p++) scan_range(f, 0, 7, 3);
        chk("stale_high", stale, 1);
        chk("frames_short_dwell", frames_seen, 4);
        chk("an_err_short_dwell", an_err_seen, exp_an_err);

        // Partial frame, then reset mid-frame; recapture starts from digit 6.
        f = mk_frame(5, 1, 5, 1, 5, 5, 1, 1);
        drive_digit(0, f[0], 20);
        chk("stale_cleared", stale, 0);
        scan_range(f, 1, 5, 20);
        do_reset();
        push(7, 0, 4, 1, 42, 1, 0, 3, 0);
        f = mk_frame(7, 0, 4, 1, 4, 2, 1, 3);
        scan_range(f, 6, 7, 20);
        scan_range(f, 0, 4, 20);
        chk("no_frame_before_all8", frames_seen, 4);
        drive_digit(5, f[5], 20);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frames_total", frames_seen, 5);
        chk("an_err_total", an_err_seen, exp_an_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
